// File: rtl/or1200_keccak_ctrl_pkg.sv
// Shared definitions for the OR1200 Keccak sponge controller.
// Contents: l.cust5 one-hot op encodings, FSM state encoding and SHA-3 pad bytes.
// No logic; imported by the pad helper and the controller top.
package or1200_keccak_ctrl_pkg;

  // l.cust5 op field, one-hot; any other value is rejected as illegal
  localparam logic [4:0] OP_INIT    = 5'b00001;
  localparam logic [4:0] OP_ABSORB  = 5'b00010;
  localparam logic [4:0] OP_LAST    = 5'b00100;
  localparam logic [4:0] OP_SQUEEZE = 5'b01000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ABS  = 3'd1,
    ST_PERM = 3'd2,
    ST_PAD  = 3'd3,
    ST_SQZ  = 3'd4
  } state_e;

  // SHA-3 domain-separation byte and final-bit byte of the pad10*1 rule
  localparam logic [7:0] PAD_DS  = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

endpackage

// File: rtl/or1200_keccak_ctrl_pad.sv
// Purpose: builds a rate word - keeps bytes below n, drops 0x06 at byte n, sets bit DW-1 on the last rate word.
// Latency: purely combinational. Backpressure: none.
// Ports: word_i data in, n_i valid byte count, first_pad_i insert 0x06, is_final_i set top bit, word_o result.
module or1200_keccak_ctrl_pad
  import or1200_keccak_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] word_i,
  input  logic [5:0]    n_i,
  input  logic          first_pad_i,
  input  logic          is_final_i,
  output logic [DW-1:0] word_o
);

  localparam int BPW = DW / 8;

  always_comb begin
    word_o = '0;
    for (int k = 0; k < BPW; k++) begin
      if (k < int'(n_i)) begin
        word_o[8*k +: 8] = word_i[8*k +: 8];
      end else if (first_pad_i && (k == int'(n_i))) begin
        word_o[8*k +: 8] = PAD_DS;
      end
    end
    // 0x06 and 0x80 may share the word when the message ends in the last rate word
    if (is_final_i) begin
      word_o[DW-1 -: 8] = word_o[DW-1 -: 8] | PAD_END;
    end
  end

endmodule

// File: rtl/or1200_keccak_ctrl.sv
// Purpose: SHA-3 sponge controller driven by l.cust5 - absorbs ALU words into the core rate, pads, permutes, squeezes.
// Latency: core write/go/clr and out32/out_valid/cmd_err are registered, one cycle after cmd_valid_i.
// Backpressure: none; commands illegal in the current state are dropped and flagged with a cmd_err_o pulse.
// Ports: cmd_*/cust5_*/a_i from the ALU; core_* to/from the permutation; keccak_en/in_ready/is_last/out32/
//        out_valid/cmd_err/hash_num_o back to the CPU.
module or1200_keccak_ctrl
  import or1200_keccak_ctrl_pkg::*;
#(
  parameter int DW         = 32,
  parameter int RATE_WORDS = 34,
  parameter int OUT_WORDS  = 8,
  parameter int HNUM_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  input  logic [4:0]        cust5_op_i,
  input  logic [5:0]        cust5_limm_i,
  input  logic [DW-1:0]     a_i,
  output logic              core_wr_en_o,
  output logic [5:0]        core_wr_idx_o,
  output logic [DW-1:0]     core_wr_data_o,
  output logic              core_go_o,
  output logic              core_clr_o,
  input  logic              core_done_i,
  output logic [5:0]        core_rd_idx_o,
  input  logic [DW-1:0]     core_rd_data_i,
  output logic              keccak_en_o,
  output logic              in_ready_o,
  output logic              is_last_o,
  output logic [DW-1:0]     out32_o,
  output logic              out_valid_o,
  output logic              cmd_err_o,
  output logic [HNUM_W-1:0] hash_num_o
);

  localparam int         BPW      = DW / 8;
  localparam logic [5:0] LAST_IDX = 6'(RATE_WORDS - 1);

  state_e              state_q, state_d;
  logic [5:0]          word_cnt_q, word_cnt_d;
  logic                pad_pending_q, pad_pending_d;
  logic                final_q, final_d;
  logic                first_pad_q, first_pad_d;
  logic [HNUM_W-1:0]   hash_num_q, hash_num_d;
  logic                wr_en_q, wr_en_d;
  logic [5:0]          wr_idx_q, wr_idx_d;
  logic [DW-1:0]       wr_data_q, wr_data_d;
  logic                go_q, go_d;
  logic                clr_q, clr_d;
  logic [DW-1:0]       out32_q, out32_d;
  logic                out_valid_q, out_valid_d;
  logic                cmd_err_q, cmd_err_d;

  // Command decode; only exact one-hot codes are recognised
  logic op_init, op_absorb, op_last, op_squeeze;
  assign op_init    = cmd_valid_i && (cust5_op_i == OP_INIT);
  assign op_absorb  = cmd_valid_i && (cust5_op_i == OP_ABSORB);
  assign op_last    = cmd_valid_i && (cust5_op_i == OP_LAST);
  assign op_squeeze = cmd_valid_i && (cust5_op_i == OP_SQUEEZE);

  logic n_full, n_ok, idx_ok, at_last_word;
  assign n_full       = ({1'b0, cust5_limm_i} == 7'(BPW));
  assign n_ok         = ({1'b0, cust5_limm_i} <= 7'(BPW));
  assign idx_ok       = ({1'b0, cust5_limm_i} <  7'(OUT_WORDS));
  assign at_last_word = (word_cnt_q == LAST_IDX);

  // One padder serves both the LAST word (from a_i) and the zero-filled PAD words
  logic          in_pad;
  logic [DW-1:0] pad_word;
  assign in_pad = (state_q == ST_PAD);

  or1200_keccak_ctrl_pad #(.DW(DW)) u_pad (
    .word_i      (in_pad ? '0 : a_i),
    .n_i         (in_pad ? 6'd0 : cust5_limm_i),
    .first_pad_i (in_pad ? first_pad_q : !n_full),
    .is_final_i  (in_pad ? at_last_word : (at_last_word && !n_full)),
    .word_o      (pad_word)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    pad_pending_d = pad_pending_q;
    final_d       = final_q;
    first_pad_d   = first_pad_q;
    hash_num_d    = hash_num_q;
    wr_en_d       = 1'b0;
    wr_idx_d      = wr_idx_q;
    wr_data_d     = wr_data_q;
    go_d          = 1'b0;
    clr_d         = 1'b0;
    out32_d       = out32_q;
    out_valid_d   = 1'b0;
    cmd_err_d     = 1'b0;

    if (op_init) begin
      // INIT beats everything, including a core_done landing in the same cycle
      state_d       = ST_ABS;
      clr_d         = 1'b1;
      word_cnt_d    = '0;
      pad_pending_d = 1'b0;
      final_d       = 1'b0;
      first_pad_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ABS: begin
          if (op_absorb) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = word_cnt_q;
            wr_data_d = a_i;
            if (at_last_word) begin
              go_d       = 1'b1;
              state_d    = ST_PERM;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + 6'd1;
            end
          end else if (op_last && n_ok) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = word_cnt_q;
            wr_data_d = pad_word;
            // A full last word leaves 0x06 still owed to the next pad word
            first_pad_d = n_full;
            if (at_last_word) begin
              // Full word in the last slot: pad spills into a fresh block after this permutation
              go_d          = 1'b1;
              state_d       = ST_PERM;
              word_cnt_d    = '0;
              pad_pending_d = n_full;
              final_d       = !n_full;
            end else begin
              state_d    = ST_PAD;
              word_cnt_d = word_cnt_q + 6'd1;
            end
          end else if (cmd_valid_i) begin
            cmd_err_d = 1'b1;
          end
        end

        ST_PERM: begin
          if (core_done_i) begin
            if (pad_pending_q) begin
              state_d       = ST_PAD;
              pad_pending_d = 1'b0;
            end else if (final_q) begin
              state_d    = ST_SQZ;
              final_d    = 1'b0;
              hash_num_d = hash_num_q + HNUM_W'(1);
            end else begin
              state_d = ST_ABS;
            end
          end
          if (cmd_valid_i) cmd_err_d = 1'b1;
        end

        ST_PAD: begin
          wr_en_d     = 1'b1;
          wr_idx_d    = word_cnt_q;
          wr_data_d   = pad_word;
          first_pad_d = 1'b0;
          if (at_last_word) begin
            go_d       = 1'b1;
            final_d    = 1'b1;
            state_d    = ST_PERM;
            word_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + 6'd1;
          end
          if (cmd_valid_i) cmd_err_d = 1'b1;
        end

        ST_SQZ: begin
          if (op_squeeze) begin
            out_valid_d = 1'b1;
            if (idx_ok) begin
              out32_d = core_rd_data_i;
            end else begin
              out32_d   = '0;
              cmd_err_d = 1'b1;
            end
          end else if (cmd_valid_i) begin
            cmd_err_d = 1'b1;
          end
        end

        default: begin
          if (cmd_valid_i) cmd_err_d = 1'b1;
        end
      endcase
    end
  end

  // Datapath and pulse registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_cnt_q    <= '0;
      pad_pending_q <= 1'b0;
      final_q       <= 1'b0;
      first_pad_q   <= 1'b0;
      hash_num_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_idx_q      <= '0;
      wr_data_q     <= '0;
      go_q          <= 1'b0;
      clr_q         <= 1'b0;
      out32_q       <= '0;
      out_valid_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      word_cnt_q    <= word_cnt_d;
      pad_pending_q <= pad_pending_d;
      final_q       <= final_d;
      first_pad_q   <= first_pad_d;
      hash_num_q    <= hash_num_d;
      wr_en_q       <= wr_en_d;
      wr_idx_q      <= wr_idx_d;
      wr_data_q     <= wr_data_d;
      go_q          <= go_d;
      clr_q         <= clr_d;
      out32_q       <= out32_d;
      out_valid_q   <= out_valid_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // State-decoded outputs; the digest select is combinational so core_rd_data_i is valid at the edge
  always_comb begin
    keccak_en_o   = (state_q != ST_IDLE);
    in_ready_o    = (state_q == ST_ABS);
    is_last_o     = (state_q == ST_SQZ);
    core_rd_idx_o = (op_squeeze && (state_q == ST_SQZ)) ? cust5_limm_i : 6'd0;
  end

  assign core_wr_en_o   = wr_en_q;
  assign core_wr_idx_o  = wr_idx_q;
  assign core_wr_data_o = wr_data_q;
  assign core_go_o      = go_q;
  assign core_clr_o     = clr_q;
  assign out32_o        = out32_q;
  assign out_valid_o    = out_valid_q;
  assign cmd_err_o      = cmd_err_q;
  assign hash_num_o     = hash_num_q;

endmodule

// File: tb/tb_or1200_keccak_ctrl.sv
// Directed bench for or1200_keccak_ctrl (DW=32, RATE_WORDS=34, OUT_WORDS=8).
// A monitor logs core writes per block; the digest core is modelled as 0xDEADBEE8 ^ idx.
// Expected values are hand-derived constants.
module tb_or1200_keccak_ctrl;
  import or1200_keccak_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int RW = 34;
  localparam int OW = 8;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [4:0]    cust5_op = '0;
  logic [5:0]    cust5_limm = '0;
  logic [DW-1:0] a = '0;
  logic          core_done = 1'b0;
  logic          core_wr_en, core_go, core_clr;
  logic [5:0]    core_wr_idx, core_rd_idx;
  logic [DW-1:0] core_wr_data, core_rd_data, out32;
  logic          keccak_en, in_ready, is_last, out_valid, cmd_err;
  logic [HW-1:0] hash_num;

  always #5 clk = ~clk;

  assign core_rd_data = 32'hDEADBEE8 ^ {26'd0, core_rd_idx};

  or1200_keccak_ctrl #(.DW(DW), .RATE_WORDS(RW), .OUT_WORDS(OW), .HNUM_W(HW)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cust5_op_i(cust5_op),
    .cust5_limm_i(cust5_limm), .a_i(a), .core_wr_en_o(core_wr_en), .core_wr_idx_o(core_wr_idx),
    .core_wr_data_o(core_wr_data), .core_go_o(core_go), .core_clr_o(core_clr),
    .core_done_i(core_done), .core_rd_idx_o(core_rd_idx), .core_rd_data_i(core_rd_data),
    .keccak_en_o(keccak_en), .in_ready_o(in_ready), .is_last_o(is_last), .out32_o(out32),
    .out_valid_o(out_valid), .cmd_err_o(cmd_err), .hash_num_o(hash_num)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] blk [0:63];
  int wr_cnt, go_cnt, clr_cnt;

  // Write log, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (core_wr_en) begin
      blk[core_wr_idx] = core_wr_data;
      wr_cnt++;
    end
    if (core_go)  go_cnt++;
    if (core_clr) clr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 64; i++) blk[i] = 32'hFFFFFFFF;
    wr_cnt = 0; go_cnt = 0; clr_cnt = 0;
  endtask

  // Issue one command: held across exactly one rising edge, returns at the next falling edge
  task automatic cmd(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] data);
    cmd_valid = 1'b1; cust5_op = op; cust5_limm = limm; a = data;
    @(negedge clk);
    cmd_valid = 1'b0; cust5_op = '0; cust5_limm = '0; a = '0;
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic wait_go(input string tag, input int n);
    for (int i = 0; i < 100 && go_cnt < n; i++) @(negedge clk);
    chk(tag, go_cnt, n);
  endtask

  function automatic logic [31:0] mid_or();
    logic [31:0] acc;
    acc = '0;
    for (int i = 1; i < RW - 1; i++) acc = acc | blk[i];
    return acc;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_log();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset asserted mid-absorb
    cmd(OP_INIT, 6'd0, 32'd0);
    for (int i = 0; i < 5; i++) cmd(OP_ABSORB, 6'd0, 32'h100 + i);
    #2 rst = 1'b1;
    #1;
    chk("rst_flags", {24'd0, keccak_en, in_ready, is_last, out_valid, cmd_err, core_wr_en, core_go, core_clr}, 32'd0);
    chk("rst_out32", out32, 32'd0);
    chk("rst_hash", {24'd0, hash_num}, 32'd0);
    chk("rst_wr_data", core_wr_data, 32'd0);
    chk("rst_wr_idx", {26'd0, core_wr_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    cmd(OP_ABSORB, 6'd0, 32'h12345678);
    chk("idle_absorb_err", {31'd0, cmd_err}, 32'd1);
    @(negedge clk);
    chk("idle_absorb_nowr", wr_cnt, 0);
    chk("idle_en", {31'd0, keccak_en}, 32'd0);

    // 2: empty message
    cmd(OP_INIT, 6'd0, 32'd0);
    chk("init_clr", {31'd0, core_clr}, 32'd1);
    chk("init_ready", {31'd0, in_ready}, 32'd1);
    clear_log();
    cmd(OP_LAST, 6'd0, 32'hFFFFFFFF);
    wait_go("empty_go", 1);
    chk("empty_wr_cnt", wr_cnt, 34);
    chk("empty_w0", blk[0], 32'h00000006);
    chk("empty_mid", mid_or(), 32'd0);
    chk("empty_w33", blk[33], 32'h80000000);
    chk("empty_perm_ready", {31'd0, in_ready}, 32'd0);
    pulse_done();
    chk("empty_is_last", {31'd0, is_last}, 32'd1);
    chk("empty_hash", {24'd0, hash_num}, 32'd1);

    // 3: 33 words then 3 bytes in the final rate word
    cmd(OP_INIT, 6'd0, 32'd0);
    clear_log();
    for (int i = 0; i < 33; i++) cmd(OP_ABSORB, 6'd0, 32'h1000 + i);
    cmd(OP_LAST, 6'd3, 32'hFF636261);
    @(negedge clk);
    chk("l3_wr_cnt", wr_cnt, 34);
    chk("l3_w5", blk[5], 32'h00001005);
    chk("l3_w33", blk[33], 32'h86636261);
    chk("l3_go", go_cnt, 1);
    pulse_done();
    chk("l3_hash", {24'd0, hash_num}, 32'd2);

    // 4: full final word, padding spills into an extra block
    cmd(OP_INIT, 6'd0, 32'd0);
    clear_log();
    for (int i = 0; i < 33; i++) cmd(OP_ABSORB, 6'd0, 32'h2000 + i);
    cmd(OP_LAST, 6'd4, 32'h64636261);
    wait_go("l4_go1", 1);
    chk("l4_w33", blk[33], 32'h64636261);
    chk("l4_wr_cnt1", wr_cnt, 34);
    clear_log();
    pulse_done();
    wait_go("l4_go2", 1);
    chk("l4_pad_cnt", wr_cnt, 34);
    chk("l4_pad_w0", blk[0], 32'h00000006);
    chk("l4_pad_mid", mid_or(), 32'd0);
    chk("l4_pad_w33", blk[33], 32'h80000000);
    chk("l4_not_last", {31'd0, is_last}, 32'd0);
    pulse_done();
    chk("l4_is_last", {31'd0, is_last}, 32'd1);
    chk("l4_hash", {24'd0, hash_num}, 32'd3);

    // 5: squeeze in range, out of range, illegal op in SQZ
    cmd_valid = 1'b1; cust5_op = OP_SQUEEZE; cust5_limm = 6'd7;
    #1;
    chk("sqz_rd_idx", {26'd0, core_rd_idx}, 32'd7);
    @(negedge clk);
    cmd_valid = 1'b0; cust5_op = '0; cust5_limm = '0;
    chk("sqz7_out32", out32, 32'hDEADBEEF);
    chk("sqz7_valid", {31'd0, out_valid}, 32'd1);
    chk("sqz7_err", {31'd0, cmd_err}, 32'd0);
    @(negedge clk);
    chk("sqz_valid_pulse", {31'd0, out_valid}, 32'd0);
    chk("sqz_hold", out32, 32'hDEADBEEF);
    cmd(OP_SQUEEZE, 6'd0, 32'd0);
    chk("sqz0_out32", out32, 32'hDEADBEE8);
    cmd(OP_SQUEEZE, 6'd8, 32'd0);
    chk("sqz8_out32", out32, 32'd0);
    chk("sqz8_valid", {31'd0, out_valid}, 32'd1);
    chk("sqz8_err", {31'd0, cmd_err}, 32'd1);
    cmd(OP_ABSORB, 6'd0, 32'h1);
    chk("sqz_absorb_err", {31'd0, cmd_err}, 32'd1);
    chk("sqz_stays", {31'd0, is_last}, 32'd1);

    // 6: INIT during PERM, late core_done is ignored
    cmd(OP_INIT, 6'd0, 32'd0);
    clear_log();
    for (int i = 0; i < 34; i++) cmd(OP_ABSORB, 6'd0, i);
    chk("p6_go", go_cnt, 1);
    chk("p6_perm", {31'd0, in_ready}, 32'd0);
    cmd(OP_INIT, 6'd0, 32'd0);
    chk("p6_clr", {31'd0, core_clr}, 32'd1);
    chk("p6_abs", {31'd0, in_ready}, 32'd1);
    pulse_done();
    chk("p6_still_abs", {31'd0, in_ready}, 32'd1);
    chk("p6_hash", {24'd0, hash_num}, 32'd3);
    clear_log();
    cmd(OP_ABSORB, 6'd0, 32'h0000A5A5);
    @(negedge clk);
    chk("p6_wr_cnt", wr_cnt, 1);
    chk("p6_w0", blk[0], 32'h0000A5A5);
    cmd(OP_LAST, 6'd5, 32'h0);
    chk("last_n5_err", {31'd0, cmd_err}, 32'd1);
    cmd(5'b00011, 6'd0, 32'h0);
    chk("bad_op_err", {31'd0, cmd_err}, 32'd1);
    @(negedge clk);
    chk("err_no_write", wr_cnt, 1);
    chk("err_keeps_abs", {31'd0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
